// File: rtl/ram_burst_pkg.sv
// Shared types and constants for the RAM burst master and its read FIFO.
package ram_burst_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    READ   = 2'd2,
    RFLUSH = 2'd3
  } state_e;

  localparam int RD_FIFO_DEPTH = 2;
  localparam int RD_CNT_W      = $clog2(RD_FIFO_DEPTH + 1);

  localparam int DEF_WORDSIZE  = 8;
  localparam int DEF_ADDRSIZE  = 9;
  localparam int DEF_WORDCOUNT = 512;
  localparam int DEF_LENBITS   = 4;

endpackage

// File: rtl/ram_burst_rdfifo.sv
// Two-entry FIFO holding {last, data} read beats; occupancy is exported for read credits.
module ram_burst_rdfifo
  import ram_burst_pkg::*;
#(
  parameter int W = DEF_WORDSIZE + 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                push,
  input  logic [W-1:0]        push_data,
  input  logic                pop,
  output logic [W-1:0]        head_data,
  output logic                empty,
  output logic [RD_CNT_W-1:0] count
);

  logic [W-1:0]        mem_q [RD_FIFO_DEPTH];
  logic [W-1:0]        mem_d [RD_FIFO_DEPTH];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [RD_CNT_W-1:0] count_q, count_d;
  logic                do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != RD_CNT_W'(RD_FIFO_DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + RD_CNT_W'(1);
      2'b01:   count_d = count_q - RD_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is data only; pointers and count flush on reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for one port of the negedge-clocked dual-port RAM.
// Define RAM_BURST_BOUNDS_CHECK_EN to reject bursts past wordcount with cmd_err instead of wrapping.
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int wordsize  = DEF_WORDSIZE,
  parameter int addrsize  = DEF_ADDRSIZE,
  parameter int wordcount = DEF_WORDCOUNT,
  parameter int lenbits   = DEF_LENBITS
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [addrsize-1:0] cmd_addr,
  input  logic [lenbits-1:0]  cmd_len,
  output logic                cmd_err,
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [wordsize-1:0] wd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [wordsize-1:0] rd_data,
  output logic                rd_last,
  output logic                busy,
  output logic [addrsize-1:0] ram_addr,
  output logic                ram_wEn,
  output logic [wordsize-1:0] ram_wDat,
  output logic                ram_rEn,
  input  logic [wordsize-1:0] ram_rDat
);

`ifdef RAM_BURST_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [addrsize-1:0] addr_q, addr_d;
  logic [lenbits:0]    remain_q, remain_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                cmd_err_q, cmd_err_d;
  logic [addrsize-1:0] ram_addr_q, ram_addr_d;
  logic [wordsize-1:0] ram_wdat_q, ram_wdat_d;
  logic                ram_wen_q, ram_wen_d;
  logic                ram_ren_q, ram_ren_d;
  logic                ren_last_q, ren_last_d;

  logic                cmd_fire;
  logic                cmd_oob;
  logic [31:0]         cmd_end;
  logic                last_beat;
  logic                rd_pop;
  logic                credit_ok;
  logic [2:0]          occ_sum;
  logic                fifo_empty;
  logic [RD_CNT_W-1:0] fifo_count;
  logic [wordsize:0]   fifo_head;

  ram_burst_rdfifo #(
    .W(wordsize + 1)
  ) u_rdfifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (ram_ren_q),
    .push_data ({ren_last_q, ram_rDat}),
    .pop       (rd_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rd_pop = !fifo_empty && rd_ready;

  // Credits: a new read may only be issued if its data is guaranteed a FIFO slot,
  // counting the read already on the RAM port and the beat leaving this cycle.
  always_comb begin
    occ_sum   = 3'(fifo_count) + {2'b00, ram_ren_q};
    credit_ok = occ_sum < (3'(RD_FIFO_DEPTH) + {2'b00, rd_pop});
  end

  always_comb begin
    cmd_fire  = cmd_valid && cmd_ready_q;
    cmd_end   = 32'(cmd_addr) + 32'(cmd_len) + 32'd1;
    cmd_oob   = BoundsEn && (cmd_end > 32'(wordcount));
    last_beat = (remain_q == (lenbits + 1)'(1));
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    cmd_err_d  = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_wdat_d = ram_wdat_q;
    ram_wen_d  = 1'b0;
    ram_ren_d  = 1'b0;
    ren_last_d = 1'b0;
    wd_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_oob) begin
            cmd_err_d = 1'b1;
          end else begin
            addr_d   = cmd_addr;
            remain_d = {1'b0, cmd_len} + (lenbits + 1)'(1);
            state_d  = cmd_write ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        wd_ready = 1'b1;
        if (wd_valid) begin
          ram_addr_d = addr_q;
          ram_wdat_d = wd_data;
          ram_wen_d  = 1'b1;
          addr_d     = addr_q + addrsize'(1);
          remain_d   = remain_q - (lenbits + 1)'(1);
          if (last_beat) state_d = IDLE;
        end
      end
      READ: begin
        if (credit_ok) begin
          ram_addr_d = addr_q;
          ram_ren_d  = 1'b1;
          ren_last_d = last_beat;
          addr_d     = addr_q + addrsize'(1);
          remain_d   = remain_q - (lenbits + 1)'(1);
          if (last_beat) state_d = RFLUSH;
        end
      end
      RFLUSH: begin
        if (fifo_empty && !ram_ren_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      cmd_ready_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdat_q  <= '0;
      ram_wen_q   <= 1'b0;
      ram_ren_q   <= 1'b0;
      ren_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_err_q   <= cmd_err_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdat_q  <= ram_wdat_d;
      ram_wen_q   <= ram_wen_d;
      ram_ren_q   <= ram_ren_d;
      ren_last_q  <= ren_last_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cmd_err   = cmd_err_q;
  assign busy      = (state_q != IDLE);
  assign ram_addr  = ram_addr_q;
  assign ram_wDat  = ram_wdat_q;
  assign ram_wEn   = ram_wen_q;
  assign ram_rEn   = ram_ren_q;
  assign rd_valid  = !fifo_empty;
  assign rd_data   = fifo_empty ? '0 : fifo_head[wordsize-1:0];
  assign rd_last   = !fifo_empty && fifo_head[wordsize];

endmodule

// File: tb/tb_ram_burst_master.sv
// Scoreboard bench for ram_burst_master with a behavioural negedge RAM on its port.
module tb_ram_burst_master;

  logic       clock;
  logic       resetn;
  logic       cmd_valid, cmd_ready, cmd_write, cmd_err;
  logic [8:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       wd_valid, wd_ready;
  logic [7:0] wd_data;
  logic       rd_valid, rd_ready, rd_last;
  logic [7:0] rd_data;
  logic       busy;
  logic [8:0] ram_addr;
  logic       ram_wEn, ram_rEn;
  logic [7:0] ram_wDat, ram_rDat;

  typedef struct packed { logic [8:0] addr; logic [7:0] data; } wr_exp_t;
  typedef struct packed { logic last; logic [7:0] data; } rd_exp_t;

  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int issued_tot = 0;
  int popped_tot = 0;
  logic       rdy_mode = 1'b0;
  logic [3:0] rdy_pat  = 4'b1001;
  int         pidx     = 0;

  logic [7:0] mem [512];

  ram_burst_master dut (
    .clock     (clock),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_err   (cmd_err),
    .wd_valid  (wd_valid),
    .wd_ready  (wd_ready),
    .wd_data   (wd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy),
    .ram_addr  (ram_addr),
    .ram_wEn   (ram_wEn),
    .ram_wDat  (ram_wDat),
    .ram_rEn   (ram_rEn),
    .ram_rDat  (ram_rDat)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // RAM stand-in: samples its port on the falling edge, one-cycle read latency.
  always @(negedge clock) begin
    if (ram_wEn) mem[ram_addr] <= ram_wDat;
    if (ram_rEn) ram_rDat <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({cmd_ready, wd_ready, rd_valid, rd_last, busy, cmd_err,
                ram_wEn, ram_rEn, ram_addr, ram_wDat});
  endfunction

  // Monitor: pops expected values whenever the DUT presents a write or a read beat.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    wr_exp_t    we;
    rd_exp_t    re;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        prev_stall = 1'b0;
      end else begin
        if (ram_wEn || ram_rEn) check("wen_ren_excl", 32'(ram_wEn & ram_rEn), 32'd0);
        if (ram_wEn) begin
          if (wr_q.size() == 0) check("unexpected_write", 32'(ram_wEn), 32'd0);
          else begin
            we = wr_q.pop_front();
            check("wr_addr", 32'(ram_addr), 32'(we.addr));
            check("wr_data", 32'(ram_wDat), 32'(we.data));
          end
        end
        if (ram_rEn) begin
          issued_tot++;
          check("reads_ahead_le2", 32'((issued_tot - popped_tot) <= 2), 32'd1);
        end
        if (prev_stall && rd_valid) begin
          check("stall_data", 32'(rd_data), 32'(prev_data));
          check("stall_last", 32'(rd_last), 32'(prev_last));
        end
        if (rd_valid && rd_ready) begin
          if (rd_q.size() == 0) check("unexpected_read", 32'(rd_valid), 32'd0);
          else begin
            re = rd_q.pop_front();
            check("rd_data", 32'(rd_data), 32'(re.data));
            check("rd_last", 32'(rd_last), 32'(re.last));
          end
          popped_tot++;
        end
        prev_stall = rd_valid && !rd_ready;
        prev_data  = rd_data;
        prev_last  = rd_last;
      end
    end
  end

  initial begin
    rd_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (rdy_mode) begin
        rd_ready = rdy_pat[pidx];
        pidx     = (pidx + 1) % 4;
      end else begin
        rd_ready = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic wr, input logic [8:0] a, input logic [3:0] l);
    int w;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    w = 0;
    @(negedge clock);
    while (!cmd_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic stream_writes(input logic [7:0] first, input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      wd_valid = 1'b1;
      wd_data  = first + 8'(i);
      w = 0;
      @(negedge clock);
      while (!wd_ready && w < 50) begin
        @(negedge clock);
        w++;
      end
      check("wd_ready_wait", 32'(wd_ready), 32'd1);
      @(posedge clock);
      #1;
    end
    wd_valid = 1'b0;
  endtask

  task automatic expect_writes(input logic [8:0] a, input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) wr_q.push_back('{addr: a + 9'(i), data: first + 8'(i)});
  endtask

  task automatic expect_reads(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) rd_q.push_back('{last: (i == n - 1), data: first + 8'(i)});
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0 || busy) && w < 200) begin
      @(posedge clock);
      #1;
      w++;
    end
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_rd_q", 32'(rd_q.size()), 32'd0);
    check("drain_wr_q", 32'(wr_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    int w;
    resetn    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wd_valid  = 1'b0;
    wd_data   = '0;
    #1 resetn = 1'b0;
    #2;
    check("reset_outputs_zero", out_vec(), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs_held", out_vec(), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_reset_busy", 32'(busy), 32'd0);
    @(posedge clock);
    #1;

    // Write burst A1..A4 at 0x010, back-to-back.
    expect_writes(9'h010, 8'hA1, 4);
    send_cmd(1'b1, 9'h010, 4'd3);
    stream_writes(8'hA1, 4);
    @(negedge clock);
    check("busy_after_last_beat", 32'(busy), 32'd0);
    check("final_wen_in_idle", 32'(ram_wEn), 32'd1);
    @(posedge clock);
    #1;
    drain();

    // Read back with rd_ready held high; first beat two cycles after handshake.
    expect_reads(8'hA1, 4);
    send_cmd(1'b0, 9'h010, 4'd3);
    @(negedge clock);
    check("rd_valid_lat_c0", 32'(rd_valid), 32'd0);
    @(negedge clock);
    check("rd_valid_lat_c1", 32'(rd_valid), 32'd0);
    @(negedge clock);
    check("rd_valid_lat_c2", 32'(rd_valid), 32'd1);
    @(posedge clock);
    #1;
    drain();

    // Same read with consumer backpressure 1,0,0,1.
    pidx     = 0;
    rdy_mode = 1'b1;
    expect_reads(8'hA1, 4);
    send_cmd(1'b0, 9'h010, 4'd3);
    drain();
    rdy_mode = 1'b0;
    @(posedge clock);
    #1;

    // Burst across the top address.
`ifdef RAM_BURST_BOUNDS_CHECK_EN
    send_cmd(1'b1, 9'h1FE, 4'd3);
    wd_valid = 1'b1;
    wd_data  = 8'hB1;
    @(negedge clock);
    check("oob_cmd_err_pulse", 32'(cmd_err), 32'd1);
    check("oob_wd_ready", 32'(wd_ready), 32'd0);
    check("oob_busy", 32'(busy), 32'd0);
    @(negedge clock);
    check("oob_cmd_err_cleared", 32'(cmd_err), 32'd0);
    check("oob_wd_ready_2", 32'(wd_ready), 32'd0);
    repeat (4) @(posedge clock);
    #1;
    wd_valid = 1'b0;
    drain();
`else
    expect_writes(9'h1FE, 8'hB1, 4);
    send_cmd(1'b1, 9'h1FE, 4'd3);
    stream_writes(8'hB1, 4);
    @(negedge clock);
    check("wrap_cmd_err", 32'(cmd_err), 32'd0);
    @(posedge clock);
    #1;
    drain();
    expect_reads(8'hB1, 4);
    send_cmd(1'b0, 9'h1FE, 4'd3);
    drain();
`endif

    // Fill 8 words, then reset in the middle of reading them back.
    expect_writes(9'h040, 8'h50, 8);
    send_cmd(1'b1, 9'h040, 4'd7);
    stream_writes(8'h50, 8);
    drain();
    expect_reads(8'h50, 8);
    base = popped_tot;
    send_cmd(1'b0, 9'h040, 4'd7);
    w = 0;
    while (popped_tot < base + 2 && w < 50) begin
      @(posedge clock);
      w++;
    end
    check("two_beats_before_reset", 32'(popped_tot - base), 32'd2);
    #2;
    resetn = 1'b0;
    rd_q.delete();
    #1;
    check("midburst_reset_outputs_zero", out_vec(), 32'd0);
    issued_tot = 0;
    popped_tot = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("after_reset_busy", 32'(busy), 32'd0);
    check("after_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("after_reset_fifo_empty", 32'(rd_valid), 32'd0);
    @(posedge clock);
    #1;

    // Single-beat read after reset.
    expect_reads(8'h50, 1);
    send_cmd(1'b0, 9'h040, 4'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
